riscv_v_wb_queue: RTL and testbench

- Sits directly downstream of the vector execute ALU stage. It captures each EXE result (vector and scalar-integer), computes per-byte vector-register write enables from vl, mask and element size, and buffers entries in a small FIFO.
- It drains entries to the vector/integer register-file write ports with a valid/ready handshake, decoupling EXE from register-file write-port stalls.
- It also provides a flush and a saturating retire counter.

---
 rtl/riscv_v_wb_queue_if.sv | 48 ++++
 rtl/riscv_v_wb_queue.sv | 168 ++++++++++++++++
 tb/tb_riscv_v_wb_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_wb_queue_if.sv
// Enqueue/drain bundle between the vector EXE stage, the write-back queue and the register-file write ports.
interface riscv_v_wb_queue_if #(
    parameter int DATA_W = 128,
    parameter int REG_AW = 5,
    parameter int INT_W  = 32,
    parameter int CNT_W  = 16
);
    localparam int NBYTES = DATA_W / 8;
    localparam int VL_W   = $clog2(NBYTES) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_vec_result;
    logic [INT_W-1:0]  in_int_result;
    logic              in_vec_we;
    logic              in_int_we;
    logic [REG_AW-1:0] in_vd;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_osize;
    logic [VL_W-1:0]   in_vl;
    logic              in_vm;
    logic [NBYTES-1:0] in_mask;
    logic              out_valid;
    logic              out_ready;
    logic              vrf_we;
    logic [REG_AW-1:0] vrf_addr;
    logic [DATA_W-1:0] vrf_wdata;
    logic [NBYTES-1:0] vrf_be;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [INT_W-1:0]  rf_wdata;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output flush, in_valid, in_vec_result, in_int_result, in_vec_we, in_int_we,
               in_vd, in_rd, in_osize, in_vl, in_vm, in_mask, out_ready,
        input  in_ready, out_valid, vrf_we, vrf_addr, vrf_wdata, vrf_be,
               rf_we, rf_addr, rf_wdata, retire_cnt
    );

    modport slave (
        input  flush, in_valid, in_vec_result, in_int_result, in_vec_we, in_int_we,
               in_vd, in_rd, in_osize, in_vl, in_vm, in_mask, out_ready,
        output in_ready, out_valid, vrf_we, vrf_addr, vrf_wdata, vrf_be,
               rf_we, rf_addr, rf_wdata, retire_cnt
    );
endinterface

// File: rtl/riscv_v_wb_queue.sv
// Vector/integer write-back queue: captures EXE results with precomputed byte enables and
// drains them to the register-file write ports, with flush and a saturating retire counter.
module riscv_v_wb_queue_chk #(
    parameter int NBYTES = 16
) (
    input logic              clk,
    input logic              rst,
    input logic              full,
    input logic              in_valid,
    input logic              in_ready,
    input logic [NBYTES-1:0] in_be,
    input logic [NBYTES-1:0] be_bound,
    input logic              vrf_we,
    input logic              out_valid
);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) full |-> !(in_valid && in_ready));
    a_be_in_vl:     assert property (@(posedge clk) disable iff (!rst) (in_be & ~be_bound) == '0);
    a_we_valid:     assert property (@(posedge clk) disable iff (!rst) vrf_we |-> out_valid);
endmodule

module riscv_v_wb_queue #(
    parameter int DATA_W = 128,
    parameter int NBYTES = DATA_W / 8,
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5,
    parameter int INT_W  = 32,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    riscv_v_wb_queue_if.slave bus
);
    localparam int VL_W = $clog2(NBYTES) + 1;
    localparam int AW   = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Byte b belongs to element b>>osize; it is enabled when that element is inside vl_eff and unmasked.
    function automatic logic [NBYTES-1:0] calc_be(input logic [1:0] osize, input logic [VL_W-1:0] vl,
                                                  input logic vm, input logic [NBYTES-1:0] mask);
        logic [VL_W-1:0]   max_el;
        logic [VL_W-1:0]   vl_eff;
        logic [VL_W-1:0]   elem;
        logic [NBYTES-1:0] be;
        max_el = VL_W'(NBYTES) >> osize;
        vl_eff = (vl < max_el) ? vl : max_el;
        be     = '0;
        for (int b = 0; b < NBYTES; b++) begin
            elem = VL_W'(b) >> osize;
            if ((elem < vl_eff) && (vm || mask[elem[VL_W-2:0]])) be[b] = 1'b1;
            else                                                 be[b] = 1'b0;
        end
        return be;
    endfunction

    logic [DATA_W-1:0] vdata_r [DEPTH];
    logic [INT_W-1:0]  idata_r [DEPTH];
    logic [REG_AW-1:0] vd_r    [DEPTH];
    logic [REG_AW-1:0] rd_r    [DEPTH];
    logic [NBYTES-1:0] be_r    [DEPTH];
    logic [DEPTH-1:0]  vwe_r;
    logic [DEPTH-1:0]  iwe_r;
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [CNT_W-1:0]  retire_cnt_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [AW-1:0]     head_s;
    logic [AW-1:0]     tail_s;
    logic [NBYTES-1:0] in_be_s;
    logic [NBYTES-1:0] be_bound_s;

    // Occupancy, handshake and enqueue byte-enable computation.
    always_comb begin
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        head_s      = rd_ptr_r[AW-1:0];
        tail_s      = wr_ptr_r[AW-1:0];
        bus.in_ready = !full_s && !bus.flush;
        push_s      = bus.in_valid && !full_s && !bus.flush;
        pop_s       = !empty_s && bus.out_ready && !bus.flush;
        be_bound_s  = calc_be(bus.in_osize, bus.in_vl, 1'b1, {NBYTES{1'b1}});
        if (bus.in_vec_we) in_be_s = calc_be(bus.in_osize, bus.in_vl, bus.in_vm, bus.in_mask);
        else               in_be_s = '0;
    end

    // Entry storage, written at the tail on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vdata_r[i] <= '0;
                idata_r[i] <= '0;
                vd_r[i]    <= '0;
                rd_r[i]    <= '0;
                be_r[i]    <= '0;
            end
            vwe_r <= '0;
            iwe_r <= '0;
        end else if (push_s) begin
            vdata_r[tail_s] <= bus.in_vec_result;
            idata_r[tail_s] <= bus.in_int_result;
            vd_r[tail_s]    <= bus.in_vd;
            rd_r[tail_s]    <= bus.in_rd;
            be_r[tail_s]    <= in_be_s;
            vwe_r[tail_s]   <= bus.in_vec_we;
            iwe_r[tail_s]   <= bus.in_int_we;
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable; flush empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (bus.flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Retire counter saturates at all-ones; zero-vl entries still count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    retire_cnt_r <= '0;
        else if (pop_s && (retire_cnt_r != '1))      retire_cnt_r <= retire_cnt_r + CNT_ONE;
    end

    // Write-port outputs come only from the head entry and read as zero while empty.
    always_comb begin
        bus.out_valid  = !empty_s;
        bus.retire_cnt = retire_cnt_r;
        bus.vrf_we     = 1'b0;
        bus.vrf_addr   = '0;
        bus.vrf_wdata  = '0;
        bus.vrf_be     = '0;
        bus.rf_we      = 1'b0;
        bus.rf_addr    = '0;
        bus.rf_wdata   = '0;
        if (!empty_s) begin
            bus.vrf_we    = pop_s && vwe_r[head_s] && (be_r[head_s] != '0);
            bus.vrf_addr  = vd_r[head_s];
            bus.vrf_wdata = vdata_r[head_s];
            bus.vrf_be    = be_r[head_s];
            bus.rf_we     = pop_s && iwe_r[head_s];
            bus.rf_addr   = rd_r[head_s];
            bus.rf_wdata  = idata_r[head_s];
        end else begin
            bus.vrf_we    = 1'b0;
        end
    end

    riscv_v_wb_queue_chk #(.NBYTES(NBYTES)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .full      (full_s),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_be     (in_be_s),
        .be_bound  (be_bound_s),
        .vrf_we    (bus.vrf_we),
        .out_valid (bus.out_valid)
    );
endmodule

// File: tb/tb_riscv_v_wb_queue.sv
// Directed bench for riscv_v_wb_queue; a second instance with a 4-bit counter covers saturation.
module tb_riscv_v_wb_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_retire = 16'd0;

    riscv_v_wb_queue_if #(.CNT_W(16)) bus ();
    riscv_v_wb_queue_if #(.CNT_W(4))  bus2 ();

    riscv_v_wb_queue #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    riscv_v_wb_queue #(.CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vwe, input logic iwe, input logic [4:0] vd, input logic [4:0] rd,
                         input logic [1:0] os, input logic [4:0] vl, input logic vm,
                         input logic [15:0] mask, input logic [127:0] vdat, input logic [31:0] idat);
        bus.in_valid      = 1'b1;
        bus.in_vec_we     = vwe;
        bus.in_int_we     = iwe;
        bus.in_vd         = vd;
        bus.in_rd         = rd;
        bus.in_osize      = os;
        bus.in_vl         = vl;
        bus.in_vm         = vm;
        bus.in_mask       = mask;
        bus.in_vec_result = vdat;
        bus.in_int_result = idat;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.vrf_we !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", bus.vrf_we, bus.rf_we); end
        checks++; if (bus.retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_retire: got %h want 0000", bus.retire_cnt); end
        checks++; if (bus.vrf_be !== 16'h0000 || bus.vrf_addr !== 5'd0 || bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_data: be %h addr %0d rf %h want zeros", bus.vrf_be, bus.vrf_addr, bus.rf_wdata); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_masked32;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 5'd3, 5'd0, 2'd2, 5'd2, 1'b0, 16'h0005, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 32'd0);
        tick();
        drive(1'b1, 1'b0, 5'd4, 5'd0, 2'd2, 5'd3, 1'b0, 16'h0005, 128'h5, 32'd0);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.vrf_we !== 1'b1) begin errors++; $display("FAIL masked_strobe: valid %b we %b want 1 1", bus.out_valid, bus.vrf_we); end
        checks++; if (bus.vrf_be !== 16'h000F) begin errors++; $display("FAIL masked_be_vl2: got %h want 000f", bus.vrf_be); end
        checks++; if (bus.vrf_addr !== 5'd3 || bus.vrf_wdata !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin errors++; $display("FAIL masked_data: addr %0d data %h", bus.vrf_addr, bus.vrf_wdata); end
        tick();
        bus.in_valid = 1'b0;
        exp_retire = exp_retire + 16'd1;
        #1;
        checks++; if (bus.vrf_be !== 16'h0F0F || bus.vrf_addr !== 5'd4) begin errors++; $display("FAIL masked_be_vl3: be %h addr %0d want 0f0f 4", bus.vrf_be, bus.vrf_addr); end
        checks++; if (bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL masked_retire: got %0d want %0d", bus.retire_cnt, exp_retire); end
        tick();
        exp_retire = exp_retire + 16'd1;
        checks++; if (bus.out_valid !== 1'b0 || bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL masked_drain: valid %b cnt %0d want 0 %0d", bus.out_valid, bus.retire_cnt, exp_retire); end
    endtask

    task automatic test_vl_clamp;
        logic [1:0]  os_t  [4] = '{2'd0, 2'd3, 2'd1, 2'd3};
        logic [4:0]  vl_t  [4] = '{5'd16, 5'd5, 5'd3, 5'd1};
        logic        vm_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] msk_t [4] = '{16'h0000, 16'h0000, 16'h0006, 16'h0000};
        logic [15:0] exp_t [4] = '{16'hFFFF, 16'hFFFF, 16'h003C, 16'h00FF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'(i + 8), 5'd0, os_t[i], vl_t[i], vm_t[i], msk_t[i], 128'(i), 32'd0);
            tick();
            bus.in_valid = 1'b0;
            #1;
            checks++; if (bus.vrf_be !== exp_t[i] || bus.vrf_we !== 1'b1) begin errors++; $display("FAIL vl_clamp_%0d: be %h we %b want %h 1", i, bus.vrf_be, bus.vrf_we, exp_t[i]); end
            tick();
            exp_retire = exp_retire + 16'd1;
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, 5'd1, 5'd0, 2'd0, 5'd16, 1'b1, 16'h0, 128'hA, 32'd0);
        tick();
        drive(1'b1, 1'b0, 5'd2, 5'd0, 2'd0, 5'd16, 1'b1, 16'h0, 128'hB, 32'd0);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready %b want 0", bus.in_ready); end
        drive(1'b1, 1'b0, 5'd3, 5'd0, 2'd0, 5'd16, 1'b1, 16'h0, 128'hC, 32'd0);
        tick();
        checks++; if (bus.vrf_addr !== 5'd1 || bus.in_ready !== 1'b0 || bus.vrf_we !== 1'b0) begin errors++; $display("FAIL bp_hold: addr %0d ready %b we %b want 1 0 0", bus.vrf_addr, bus.in_ready, bus.vrf_we); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.vrf_we !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_a: we %b ready %b want 1 0", bus.vrf_we, bus.in_ready); end
        tick();
        checks++; if (bus.vrf_addr !== 5'd2 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_order_b: addr %0d ready %b want 2 1", bus.vrf_addr, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.vrf_addr !== 5'd3 || bus.vrf_wdata !== 128'hC) begin errors++; $display("FAIL bp_order_c: addr %0d data %h want 3 c", bus.vrf_addr, bus.vrf_wdata); end
        tick();
        exp_retire = exp_retire + 16'd3;
        checks++; if (bus.out_valid !== 1'b0 || bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL bp_drain: valid %b cnt %0d want 0 %0d", bus.out_valid, bus.retire_cnt, exp_retire); end
    endtask

    task automatic test_int_zero_vl;
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b1, 5'd9, 5'd7, 2'd0, 5'd16, 1'b1, 16'h0, 128'h1, 32'hDEADBEEF);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL int_write: we %b addr %0d data %h want 1 7 deadbeef", bus.rf_we, bus.rf_addr, bus.rf_wdata); end
        checks++; if (bus.vrf_we !== 1'b0 || bus.vrf_be !== 16'h0000) begin errors++; $display("FAIL int_no_vrf: we %b be %h want 0 0000", bus.vrf_we, bus.vrf_be); end
        tick();
        drive(1'b1, 1'b0, 5'd5, 5'd0, 2'd1, 5'd0, 1'b1, 16'hFFFF, 128'h2, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.vrf_we !== 1'b0 || bus.vrf_be !== 16'h0000) begin errors++; $display("FAIL zero_vl: valid %b we %b be %h want 1 0 0000", bus.out_valid, bus.vrf_we, bus.vrf_be); end
        tick();
        exp_retire = exp_retire + 16'd2;
        checks++; if (bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL zero_vl_retire: got %0d want %0d", bus.retire_cnt, exp_retire); end
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 5'd2, 2'd0, 5'd16, 1'b1, 16'h0, 128'hA, 32'h1);
        tick();
        drive(1'b1, 1'b1, 5'd3, 5'd4, 2'd0, 5'd16, 1'b1, 16'h0, 128'hB, 32'h2);
        tick();
        drive(1'b1, 1'b1, 5'd5, 5'd6, 2'd0, 5'd16, 1'b1, 16'h0, 128'hC, 32'h3);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.vrf_we !== 1'b0 || bus.rf_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_gate: vwe %b rwe %b ready %b want 0 0 0", bus.vrf_we, bus.rf_we, bus.in_ready); end
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL flush_empty: valid %b ready %b cnt %0d want 0 1 %0d", bus.out_valid, bus.in_ready, bus.retire_cnt, exp_retire); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.retire_cnt !== exp_retire) begin errors++; $display("FAIL flush_dropped: valid %b cnt %0d want 0 %0d", bus.out_valid, bus.retire_cnt, exp_retire); end
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd11, 5'd12, 2'd0, 5'd16, 1'b1, 16'h0, 128'hD, 32'h4);
        tick();
        drive(1'b1, 1'b1, 5'd13, 5'd14, 2'd0, 5'd16, 1'b1, 16'h0, 128'hE, 32'h5);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.vrf_addr !== 5'd0 || bus.vrf_be !== 16'h0000 || bus.rf_addr !== 5'd0) begin errors++; $display("FAIL arst_outputs: valid %b addr %0d be %h raddr %0d want zeros", bus.out_valid, bus.vrf_addr, bus.vrf_be, bus.rf_addr); end
        checks++; if (bus.retire_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_state: cnt %0d ready %b want 0 1", bus.retire_cnt, bus.in_ready); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.vrf_we !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL arst_strobes: %b%b want 00", bus.vrf_we, bus.rf_we); end
        @(negedge clk);
        rst = 1'b1;
        exp_retire = 16'd0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_after: valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_saturation;
        bus2.in_valid  = 1'b1;
        bus2.in_vec_we = 1'b1;
        bus2.in_vl     = 5'd16;
        bus2.in_vm     = 1'b1;
        bus2.out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (bus2.retire_cnt !== 4'd7) begin errors++; $display("FAIL sat_count: got %0d want 7", bus2.retire_cnt); end
        repeat (8) tick();
        checks++; if (bus2.retire_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach: got %h want f", bus2.retire_cnt); end
        repeat (5) tick();
        checks++; if (bus2.retire_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h want f", bus2.retire_cnt); end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_vec_result = '0; bus.in_int_result = '0; bus.in_vec_we = 1'b0; bus.in_int_we = 1'b0;
        bus.in_vd = '0; bus.in_rd = '0; bus.in_osize = '0; bus.in_vl = '0; bus.in_vm = 1'b0; bus.in_mask = '0;
        bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.in_vec_result = '0; bus2.in_int_result = '0; bus2.in_vec_we = 1'b0; bus2.in_int_we = 1'b0;
        bus2.in_vd = '0; bus2.in_rd = '0; bus2.in_osize = '0; bus2.in_vl = '0; bus2.in_vm = 1'b0; bus2.in_mask = '0;
        test_reset();
        test_masked32();
        test_vl_clamp();
        test_backpressure();
        test_int_zero_vl();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
